// File: rtl/bus_arbiter_n_if.sv
// rtl/bus_arbiter_n_if.sv - handshake bundle between requesting masters, slaves and the bus arbiter
//
// Purpose : groups the request/response inputs and the grant/phase outputs of bus_arbiter_n.
// Signals : busreq, split_clr  per-master request level and split release pulse
//           ready, response    slave completion handshake (00 OKAY, 01 ERROR, 10 RETRY, 11 SPLIT)
//           grant, master_sel  one-hot grant and granted index
//           addr_phase, data_phase, error, split_mask  phase enables, error pulse, parked masters
// Modports: master - requester/slave side (drives requests and responses)
//           slave  - arbiter side (drives grants and phase enables)

interface bus_arbiter_n_if #(
  parameter int NUM_MASTERS = 2,
  parameter int MID_W       = 1
);
  logic [NUM_MASTERS-1:0] busreq;
  logic [NUM_MASTERS-1:0] split_clr;
  logic                   ready;
  logic [1:0]             response;
  logic [NUM_MASTERS-1:0] grant;
  logic [MID_W-1:0]       master_sel;
  logic                   addr_phase;
  logic                   data_phase;
  logic                   error;
  logic [NUM_MASTERS-1:0] split_mask;

  modport master (
    output busreq, split_clr, ready, response,
    input  grant, master_sel, addr_phase, data_phase, error, split_mask
  );

  modport slave (
    input  busreq, split_clr, ready, response,
    output grant, master_sel, addr_phase, data_phase, error, split_mask
  );
endinterface

// File: rtl/bus_arbiter_n.sv
// rtl/bus_arbiter_n.sv - N-master bus arbiter and address/data phase sequencer
//
// Purpose : selects one of NUM_MASTERS requesters (fixed priority or round-robin), sequences
//           ADDR/DATA phases, runs bounded bursts and handles ERROR/RETRY/SPLIT responses.
// Ports   : clk  rising-edge clock
//           rst  synchronous active-high reset
//           bus  bus_arbiter_n_if.slave (busreq, split_clr, ready, response in;
//                grant, master_sel, addr_phase, data_phase, error, split_mask out)
// All outputs come straight from flops.

module bus_arbiter_n #(
  parameter int NUM_MASTERS = 2,
  parameter int MID_W       = 1,
  parameter int BURST_MAX   = 4,
  parameter int CNT_W       = 3,
  parameter int RR_MODE     = 0
) (
  input  logic           clk,
  input  logic           rst,
  bus_arbiter_n_if.slave bus
);

  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;
  localparam logic [1:0] RESP_RETRY = 2'b10;
  localparam logic [1:0] RESP_SPLIT = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [NUM_MASTERS-1:0] split_mask_q, split_mask_d;
  logic [MID_W-1:0]       master_sel_q, master_sel_d;
  logic [MID_W-1:0]       last_winner_q, last_winner_d;
  logic [CNT_W-1:0]       beat_cnt_q, beat_cnt_d;
  logic                   addr_phase_q, addr_phase_d;
  logic                   data_phase_q, data_phase_d;
  logic                   error_q, error_d;

  logic [NUM_MASTERS-1:0] eligible;
  logic [MID_W-1:0]       winner;
  logic [MID_W-1:0]       cand;
  logic                   any_eligible;
  logic [CNT_W-1:0]       beat_inc;

  // Winner selection. Both loops scan from the least preferred candidate to the most
  // preferred, so the last hit is the winner and no early exit is needed.
  always_comb begin
    eligible     = bus.busreq & ~split_mask_q;
    winner       = '0;
    cand         = '0;
    any_eligible = 1'b0;
    if (RR_MODE == 0) begin
      for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
        if (eligible[i]) begin
          winner       = MID_W'(i);
          any_eligible = 1'b1;
        end
      end
    end else begin
      // Offset 1 (the master just after the previous winner) is most preferred;
      // offset NUM_MASTERS brings the previous winner itself back last.
      for (int off = NUM_MASTERS; off >= 1; off--) begin
        cand = MID_W'((int'(last_winner_q) + off) % NUM_MASTERS);
        if (eligible[cand]) begin
          winner       = cand;
          any_eligible = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    master_sel_d  = master_sel_q;
    last_winner_d = last_winner_q;
    beat_cnt_d    = beat_cnt_q;
    addr_phase_d  = 1'b0;
    data_phase_d  = 1'b0;
    error_d       = 1'b0;
    beat_inc      = beat_cnt_q + CNT_W'(1);
    // Clear first so a SPLIT below overrides a same-cycle release of the same bit.
    split_mask_d  = split_mask_q & ~bus.split_clr;

    case (state_q)
      IDLE: begin
        grant_d = '0;
        if (any_eligible) begin
          grant_d         = '0;
          grant_d[winner] = 1'b1;
          master_sel_d    = winner;
          last_winner_d   = winner;
          beat_cnt_d      = '0;
          addr_phase_d    = 1'b1;
          state_d         = ADDR;
        end
      end

      ADDR: begin
        data_phase_d = 1'b1;
        state_d      = DATA;
      end

      DATA: begin
        data_phase_d = 1'b1;
        if (bus.ready) begin
          case (bus.response)
            RESP_OKAY: begin
              beat_cnt_d = beat_inc;
              if (bus.busreq[master_sel_q] && (beat_inc < CNT_W'(BURST_MAX))) begin
                addr_phase_d = 1'b1;
                data_phase_d = 1'b0;
                state_d      = ADDR;
              end else begin
                grant_d      = '0;
                data_phase_d = 1'b0;
                state_d      = IDLE;
              end
            end
            RESP_ERROR: begin
              error_d      = 1'b1;
              grant_d      = '0;
              data_phase_d = 1'b0;
              state_d      = IDLE;
            end
            RESP_RETRY: begin
              addr_phase_d = 1'b1;
              data_phase_d = 1'b0;
              state_d      = ADDR;
            end
            RESP_SPLIT: begin
              split_mask_d[master_sel_q] = 1'b1;
              grant_d      = '0;
              data_phase_d = 1'b0;
              state_d      = IDLE;
            end
            default: ;
          endcase
        end
      end

      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      master_sel_q  <= '0;
      last_winner_q <= MID_W'(NUM_MASTERS - 1);
      beat_cnt_q    <= '0;
      addr_phase_q  <= 1'b0;
      data_phase_q  <= 1'b0;
      error_q       <= 1'b0;
      split_mask_q  <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      master_sel_q  <= master_sel_d;
      last_winner_q <= last_winner_d;
      beat_cnt_q    <= beat_cnt_d;
      addr_phase_q  <= addr_phase_d;
      data_phase_q  <= data_phase_d;
      error_q       <= error_d;
      split_mask_q  <= split_mask_d;
    end
  end

  assign bus.grant      = grant_q;
  assign bus.master_sel = master_sel_q;
  assign bus.addr_phase = addr_phase_q;
  assign bus.data_phase = data_phase_q;
  assign bus.error      = error_q;
  assign bus.split_mask = split_mask_q;

endmodule

// File: tb/tb_bus_arbiter_n.sv
// tb/tb_bus_arbiter_n.sv - scoreboard bench for a fixed-priority and a round-robin bus_arbiter_n
//
// dut0: 2 masters, fixed priority, bursts of 4.  dut1: 4 masters, round-robin, single beats.
// Each step drives one cycle of inputs and queues the outputs expected after the next edge;
// the monitor pops and compares on the falling edge.

module tb_bus_arbiter_n;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bus_arbiter_n_if #(.NUM_MASTERS(2), .MID_W(1)) if0 ();
  bus_arbiter_n_if #(.NUM_MASTERS(4), .MID_W(2)) if1 ();

  bus_arbiter_n #(.NUM_MASTERS(2), .MID_W(1), .BURST_MAX(4), .CNT_W(3), .RR_MODE(0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (if0)
  );

  bus_arbiter_n #(.NUM_MASTERS(4), .MID_W(2), .BURST_MAX(1), .CNT_W(3), .RR_MODE(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (if1)
  );

  typedef struct {
    int          dut;
    logic [12:0] v;    // {grant[3:0], sel[1:0], addr_phase, data_phase, error, split_mask[3:0]}
    string       nm;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t        e;
      logic [12:0] act;
      e = exp_q.pop_front();
      if (e.dut == 0)
        act = {2'b00, if0.grant, 1'b0, if0.master_sel, if0.addr_phase, if0.data_phase,
               if0.error, 2'b00, if0.split_mask};
      else
        act = {if1.grant, if1.master_sel, if1.addr_phase, if1.data_phase,
               if1.error, if1.split_mask};
      total++;
      if (act !== e.v) begin
        bad++;
        $display("FAIL %s dut%0d: got g=%b s=%0d ap=%b dp=%b er=%b sm=%b, want g=%b s=%0d ap=%b dp=%b er=%b sm=%b",
                 e.nm, e.dut, act[12:9], act[8:7], act[6], act[5], act[4], act[3:0],
                 e.v[12:9], e.v[8:7], e.v[6], e.v[5], e.v[4], e.v[3:0]);
      end
    end
  end

  task automatic step(input int d, input logic r, input logic [3:0] req, input logic [3:0] clr,
                      input logic rdy, input logic [1:0] resp,
                      input logic [3:0] g, input logic [1:0] s, input logic ap, input logic dp,
                      input logic er, input logic [3:0] sm, input string nm);
    exp_t e;
    rst = r;
    if (d == 0) begin
      if0.busreq = req[1:0]; if0.split_clr = clr[1:0]; if0.ready = rdy; if0.response = resp;
      if1.busreq = '0; if1.split_clr = '0; if1.ready = 1'b0; if1.response = 2'b00;
    end else begin
      if1.busreq = req; if1.split_clr = clr; if1.ready = rdy; if1.response = resp;
      if0.busreq = '0; if0.split_clr = '0; if0.ready = 1'b0; if0.response = 2'b00;
    end
    e.dut = d;
    e.v   = {g, s, ap, dp, er, sm};
    e.nm  = nm;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state of both instances
    step(0, 1, 4'b0000, 0, 0, 2'b00, 4'b0000, 0, 0, 0, 0, 4'b0000, "rst_fp");
    step(1, 1, 4'b0000, 0, 0, 2'b00, 4'b0000, 0, 0, 0, 0, 4'b0000, "rst_rr");

    // Fixed priority, both requesting: four beats to master 0, one IDLE, master 0 again
    for (int b = 0; b < 4; b++) begin
      step(0, 0, 4'b0011, 0, 1, 2'b00, 4'b0001, 0, 1, 0, 0, 4'b0000, "burst_addr");
      step(0, 0, 4'b0011, 0, 1, 2'b00, 4'b0001, 0, 0, 1, 0, 4'b0000, "burst_data");
    end
    step(0, 0, 4'b0011, 0, 1, 2'b00, 4'b0000, 0, 0, 0, 0, 4'b0000, "burst_limit_idle");
    step(0, 0, 4'b0011, 0, 1, 2'b00, 4'b0001, 0, 1, 0, 0, 4'b0000, "fixed_regrant_m0");
    step(0, 0, 4'b0011, 0, 1, 2'b00, 4'b0001, 0, 0, 1, 0, 4'b0000, "fixed_data");
    step(0, 0, 4'b0000, 0, 1, 2'b00, 4'b0000, 0, 0, 0, 0, 4'b0000, "req_drop_ends");

    // Wait states then RETRY; RETRY must not consume a beat of the burst
    step(0, 0, 4'b0001, 0, 0, 2'b00, 4'b0001, 0, 1, 0, 0, 4'b0000, "retry_addr");
    step(0, 0, 4'b0001, 0, 0, 2'b00, 4'b0001, 0, 0, 1, 0, 4'b0000, "retry_data");
    for (int w = 0; w < 3; w++)
      step(0, 0, 4'b0001, 0, 0, 2'b10, 4'b0001, 0, 0, 1, 0, 4'b0000, "wait_state");
    step(0, 0, 4'b0001, 0, 1, 2'b10, 4'b0001, 0, 1, 0, 0, 4'b0000, "retry_to_addr");
    step(0, 0, 4'b0001, 0, 1, 2'b00, 4'b0001, 0, 0, 1, 0, 4'b0000, "retry_data2");
    for (int b = 0; b < 3; b++) begin
      step(0, 0, 4'b0001, 0, 1, 2'b00, 4'b0001, 0, 1, 0, 0, 4'b0000, "post_retry_addr");
      step(0, 0, 4'b0001, 0, 1, 2'b00, 4'b0001, 0, 0, 1, 0, 4'b0000, "post_retry_data");
    end
    step(0, 0, 4'b0001, 0, 1, 2'b00, 4'b0000, 0, 0, 0, 0, 4'b0000, "post_retry_limit");
    step(0, 0, 4'b0000, 0, 1, 2'b00, 4'b0000, 0, 0, 0, 0, 4'b0000, "idle_quiet");

    // SPLIT parks master 0; master 1 served; release; set-beats-clear
    step(0, 0, 4'b0011, 0, 1, 2'b00, 4'b0001, 0, 1, 0, 0, 4'b0000, "split_addr");
    step(0, 0, 4'b0011, 0, 1, 2'b00, 4'b0001, 0, 0, 1, 0, 4'b0000, "split_data");
    step(0, 0, 4'b0011, 0, 1, 2'b11, 4'b0000, 0, 0, 0, 0, 4'b0001, "split_resp");
    step(0, 0, 4'b0011, 0, 1, 2'b00, 4'b0010, 1, 1, 0, 0, 4'b0001, "split_m1_addr");
    step(0, 0, 4'b0011, 0, 1, 2'b00, 4'b0010, 1, 0, 1, 0, 4'b0001, "split_m1_data");
    step(0, 0, 4'b0001, 0, 1, 2'b00, 4'b0000, 1, 0, 0, 0, 4'b0001, "split_m1_done");
    step(0, 0, 4'b0001, 0, 1, 2'b00, 4'b0000, 1, 0, 0, 0, 4'b0001, "split_m0_ignored");
    step(0, 0, 4'b0001, 4'b0001, 1, 2'b00, 4'b0000, 1, 0, 0, 0, 4'b0000, "split_clr");
    step(0, 0, 4'b0001, 0, 1, 2'b00, 4'b0001, 0, 1, 0, 0, 4'b0000, "unsplit_grant");
    step(0, 0, 4'b0001, 0, 1, 2'b00, 4'b0001, 0, 0, 1, 0, 4'b0000, "unsplit_data");
    step(0, 0, 4'b0001, 4'b0001, 1, 2'b11, 4'b0000, 0, 0, 0, 0, 4'b0001, "set_beats_clr");
    step(0, 0, 4'b0000, 4'b0001, 0, 2'b00, 4'b0000, 0, 0, 0, 0, 4'b0000, "clr_again");

    // ERROR pulse coincides with IDLE; next request granted on the following cycle
    step(0, 0, 4'b0001, 0, 1, 2'b00, 4'b0001, 0, 1, 0, 0, 4'b0000, "err_addr");
    step(0, 0, 4'b0001, 0, 1, 2'b00, 4'b0001, 0, 0, 1, 0, 4'b0000, "err_data");
    step(0, 0, 4'b0010, 0, 1, 2'b01, 4'b0000, 0, 0, 0, 1, 4'b0000, "err_pulse");
    step(0, 0, 4'b0010, 0, 1, 2'b00, 4'b0010, 1, 1, 0, 0, 4'b0000, "err_next_grant");
    step(0, 0, 4'b0010, 0, 1, 2'b00, 4'b0010, 1, 0, 1, 0, 4'b0000, "err_next_data");
    step(0, 0, 4'b0000, 0, 1, 2'b00, 4'b0000, 1, 0, 0, 0, 4'b0000, "err_next_done");

    // Round-robin rotation over four masters, single-beat ownership
    for (int k = 0; k < 4; k++) begin
      step(1, 0, 4'b1111, 0, 1, 2'b00, 4'(1 << k), 2'(k), 1, 0, 0, 4'b0000, "rr_addr");
      step(1, 0, 4'b1111, 0, 1, 2'b00, 4'(1 << k), 2'(k), 0, 1, 0, 4'b0000, "rr_data");
      step(1, 0, 4'b1111, 0, 1, 2'b00, 4'b0000,    2'(k), 0, 0, 0, 4'b0000, "rr_gap");
    end
    step(1, 0, 4'b1111, 0, 1, 2'b00, 4'b0001, 0, 1, 0, 0, 4'b0000, "rr_wrap");
    step(1, 0, 4'b1111, 0, 1, 2'b00, 4'b0001, 0, 0, 1, 0, 4'b0000, "rr_wrap_data");
    step(1, 0, 4'b1111, 0, 1, 2'b11, 4'b0000, 0, 0, 0, 0, 4'b0001, "rr_split");
    step(1, 0, 4'b1111, 0, 1, 2'b00, 4'b0010, 1, 1, 0, 0, 4'b0001, "rr_after_split");
    step(1, 0, 4'b1111, 0, 1, 2'b00, 4'b0010, 1, 0, 1, 0, 4'b0001, "rr_pre_reset");

    // Reset in DATA clears everything; round-robin restarts at master 0
    step(1, 1, 4'b1111, 0, 1, 2'b00, 4'b0000, 0, 0, 0, 0, 4'b0000, "reset_in_data");
    step(1, 0, 4'b1111, 0, 1, 2'b00, 4'b0001, 0, 1, 0, 0, 4'b0000, "rr_first_after_rst");
    step(1, 0, 4'b1111, 0, 1, 2'b00, 4'b0001, 0, 0, 1, 0, 4'b0000, "rr_first_data");
    step(1, 0, 4'b0000, 0, 1, 2'b00, 4'b0000, 0, 0, 0, 0, 4'b0000, "rr_first_done");

    // Sparse requests: search skips non-requesting masters and wraps
    step(1, 0, 4'b1010, 0, 1, 2'b00, 4'b0010, 1, 1, 0, 0, 4'b0000, "rr_sparse_m1");
    step(1, 0, 4'b1010, 0, 1, 2'b00, 4'b0010, 1, 0, 1, 0, 4'b0000, "rr_sparse_d1");
    step(1, 0, 4'b1010, 0, 1, 2'b00, 4'b0000, 1, 0, 0, 0, 4'b0000, "rr_sparse_gap");
    step(1, 0, 4'b1010, 0, 1, 2'b00, 4'b1000, 3, 1, 0, 0, 4'b0000, "rr_sparse_m3");
    step(1, 0, 4'b1010, 0, 1, 2'b00, 4'b1000, 3, 0, 1, 0, 4'b0000, "rr_sparse_d3");
    step(1, 0, 4'b0000, 0, 1, 2'b00, 4'b0000, 3, 0, 0, 0, 4'b0000, "rr_sparse_done");

    repeat (2) @(posedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
